// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: control word, access size and FSM states.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic      mem_read;
    logic      mem_write;
    mem_size_t mem_size;
    logic      mem_unsigned;
  } control_type;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } mem_state_t;

  localparam control_type CTRL_ZERO = '0;

  // Halves need an even address, words (and the unused size code) need a 4-byte boundary.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between the access stage and memory.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_mem_lane_align.sv
// Byte-lane steering: store-side enables/replication and load-side lane extract with extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  mem_size_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  mem_size_t   ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      MEM_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_H: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_data = ld_rdata;
    case (ld_size)
      MEM_B:   ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      MEM_H:   ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage. States: IDLE = accept from execute | REQ = dmem_req held until gnt |
// WAIT_R = granted, waiting for rvalid. Either wait state gives up after TIMEOUT_CYCLES.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  control_type               control_in,
  input  logic [31:0]               alu_data,
  input  logic [31:0]               memory_data,
  mem_access_stage_if.master        dmem,
  output logic                      out_valid,
  output control_type               control_out,
  output logic [31:0]               wb_data,
  output logic                      misaligned,
  output logic                      bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  control_type       ctrl_q, ctrl_d;
  logic [31:0]       alu_q, alu_d;
  logic              out_valid_q, out_valid_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        timeout;
  logic        complete;

  mem_lane_align u_lane (
    .st_size     (control_in.mem_size),
    .st_off      (alu_data[1:0]),
    .st_data     (memory_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (ctrl_q.mem_size),
    .ld_unsigned (ctrl_q.mem_unsigned),
    .ld_off      (alu_q[1:0]),
    .ld_rdata    (dmem.dmem_rdata),
    .ld_data     (ld_data)
  );

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    alu_d        = alu_q;
    out_valid_d  = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    wb_data_d    = wb_data_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d = control_in;
          alu_d  = alu_data;
          if (!(control_in.mem_read || control_in.mem_write)) begin
            out_valid_d = 1'b1;
            wb_data_d   = alu_data;
          end else if (is_misaligned(control_in.mem_size, alu_data[1:0])) begin
            out_valid_d  = 1'b1;
            misaligned_d = 1'b1;
            wb_data_d    = alu_data;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = control_in.mem_write;
            addr_d  = {alu_data[ADDR_W-1:2], 2'b00};
            be_d    = st_be;
            wdata_d = st_wdata;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          req_d    = 1'b0;
          cnt_d    = '0;
          state_d  = WAIT_R;
          complete = dmem.dmem_rvalid;
        end else if (timeout) begin
          req_d       = 1'b0;
          state_d     = IDLE;
          out_valid_d = 1'b1;
          bus_error_d = 1'b1;
          wb_data_d   = alu_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          complete = 1'b1;
        end else if (timeout) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          bus_error_d = 1'b1;
          wb_data_d   = alu_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d     = IDLE;
      out_valid_d = 1'b1;
      wb_data_d   = we_q ? alu_q : ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ctrl_q       <= CTRL_ZERO;
      alu_q        <= '0;
      out_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      wb_data_q    <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      alu_q        <= alu_d;
      out_valid_q  <= out_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      wb_data_q    <= wb_data_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = out_valid_q;
  assign control_out     = ctrl_q;
  assign wb_data         = wb_data_q;
  assign misaligned      = misaligned_q;
  assign bus_error       = bus_error_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execution stage.
- Takes alu_data (the effective address), memory_data (the store data) and control_type from execute.
- Performs byte/half/word loads and stores over a req/gnt/rvalid data-memory port, then presents the result to write-back.
- Non-memory ops pass through with one cycle of latency; memory ops stall upstream until the access completes or times out.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for dmem_gnt or dmem_rvalid before flagging bus_error.
- ADDR_W, 32: data-memory address width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset). Name kept for codebase consistency.
- in_valid  in  1  execute presents a valid instruction.
- in_ready  out  1  stage can accept; execute holds its outputs while low.
- control_in  in  control_type  decoded control from execute (common package).
- alu_data  in  32  ALU result / effective address.
- memory_data  in  32  store data (rs2).
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (addr[1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data shifted into lane position.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid (also returned for stores as write ack).
- dmem_rdata  in  32  load data.
- out_valid  out  1  result valid to write-back (one-cycle pulse per instruction).
- control_out  out  control_type  registered copy of control_in.
- wb_data  out  32  load result (extended) or alu_data passthrough.
- misaligned  out  1  valid with out_valid; access not naturally aligned.
- bus_error  out  1  valid with out_valid; timeout occurred.

Behaviour:
- Reset: state=IDLE; out_valid, dmem_req, dmem_we, misaligned, bus_error = 0; wb_data, dmem_addr, dmem_wdata = 0; dmem_be = 0; control_out = all-zero control_type; in_ready = 1; timeout counter = 0. Reset mid-access abandons it; a late dmem_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, accept (in_valid & in_ready), no mem op:
  - Next cycle: out_valid=1, wb_data=alu_data, control_out=control_in.
  - Stay IDLE; throughput 1/cycle.
- IDLE, accept, mem op, misaligned:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - No dmem_req is issued.
  - Next cycle: out_valid=1, misaligned=1, wb_data=alu_data.
- IDLE, accept, mem op, aligned:
  - Register address, size and data; go to REQ. in_ready=0 from the next cycle until return to IDLE.
- REQ:
  - dmem_req=1 with stable addr/we/be/wdata until gnt.
  - On dmem_gnt go to WAIT_R; dmem_req drops the following cycle.
  - Counter increments while waiting; at TIMEOUT_CYCLES go to IDLE with out_valid=1, bus_error=1.
- WAIT_R:
  - On dmem_rvalid go to IDLE with out_valid=1 the next cycle.
  - Load: wb_data = extended lane. Store: wb_data=alu_data.
  - Counter is reset on entry; timeout is handled as in REQ.
- gnt and rvalid in the same cycle while in REQ: treat as completion (skip WAIT_R).
- Byte enables and lane placement:
  - byte: be = 0001<<a[1:0]; wdata = {4{d[7:0]}}.
  - half: be = 0011<<a[1:0]; wdata = {2{d[15:0]}}.
  - word: be = 1111; wdata = d.
- Load extension:
  - Select the lane by the registered a[1:0].
  - Sign-extend unless mem_unsigned; zero-extend if set.
- Flags and timing:
  - out_valid is never asserted for two cycles by one instruction.
  - misaligned and bus_error are 0 whenever out_valid=0.
  - in_ready is combinational: 1 only in IDLE.

Decomposition:
- common package gets:
  - mem_size_t enum: MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - control_type fields mem_read, mem_write, mem_size, mem_unsigned.
  - mem_state_t enum: IDLE/REQ/WAIT_R.
- One sub-module, mem_lane_align: combinational.
  - Store side: be/wdata generation.
  - Load side: lane extract and extend.
- The FSM and registers stay in mem_access_stage.

Test Plan:
- Passthrough: ALU op, alu_data=0x0000_1234 -> one cycle later out_valid=1, wb_data=0x0000_1234, no dmem_req; back-to-back ops at 1/cycle.
- Store byte: addr=0x103, data=0xAABB_CC5A, gnt after 2 cycles, rvalid after 1 -> dmem_be=1000, dmem_wdata=0x5A5A_5A5A, dmem_addr=0x100; in_ready low throughout.
- Load half: addr=0x202, rdata=0x8001_0000 -> signed: wb_data=0xFFFF_8001; unsigned: wb_data=0x0000_8001.
- Misaligned word load at 0x302 -> no dmem_req; out_valid=1, misaligned=1 next cycle.
- Timeout: gnt held 0 -> after 16 cycles, out_valid=1, bus_error=1, state IDLE, in_ready=1.
- Reset asserted in WAIT_R, then rvalid pulse -> all outputs at reset values; no out_valid generated.
